alu_issue_ctrl: RTL and testbench
=================================

Name: alu_issue_ctrl

Overview:
Issue/sequencing controller that drives the datapath ALU's one-hot operation interface. It accepts a decoded-register R-type instruction over a valid/ready handshake and decodes the funct field into the ALU's one-hot op strobes. It sequences operand setup, ALU enable and result capture, then returns the result over a valid/ready handshake to writeback. It sits between the register-read stage and writeback.

Parameters:
MULDIV_LAT, 4, cycles alu_enable is held high for MUL/DIV (>=1)
DATA_W, 32, operand/result width

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
instr_valid  in  1  instruction offered
instr_ready  out  1  controller can accept (high only in IDLE)
instr  in  32  instruction word (opcode[31:26], rd[15:11], shamt[10:6], funct[5:0])
rs_val  in  DATA_W  rs register value
rt_val  in  DATA_W  rt register value
alu_a, alu_b, alu_c  out  DATA_W  ALU operands: rs, rt, zero-extended shamt
op_add, op_addu, op_sub, op_subu, op_mul, op_div, op_and, op_or, op_xor, op_nor, op_srl, op_sll, op_sra, op_sla  out  1 each  one-hot ALU op strobes
alu_enable  out  1  ALU enable
alu_result  in  DATA_W  ALU output
res_valid  out  1  result available
res_ready  in  1  writeback accepts result
res_data  out  DATA_W  captured result
res_dest  out  5  rd of the instruction
res_illegal  out  1  instruction was not a supported R-type op

Behaviour:
- Reset: state IDLE; all outputs 0 except instr_ready=1. Reset mid-operation aborts in-flight instruction; no result emitted.
- States: IDLE, SETUP, EXEC, RESP.
- IDLE: instr_ready=1. On instr_valid: register operands, rd and decoded op; go SETUP (legal) or RESP (illegal).
- Decode (opcode must be 0): funct 0x20 add, 0x21 addu, 0x22 sub, 0x23 subu, 0x24 and, 0x25 or, 0x26 xor, 0x27 nor, 0x00 sll, 0x02 srl, 0x03 sra, 0x01 sla, 0x18 mul, 0x1A div. Anything else, or opcode!=0, is illegal.
- SETUP (1 cycle): operands and exactly one op strobe driven; alu_enable=0 so the ALU sees a clean enable rising edge with stable inputs.
- EXEC: alu_enable=1, strobes and operands held. Length is 1 cycle, or MULDIV_LAT cycles for mul/div (down-counter loaded on SETUP entry). On the last EXEC cycle, capture alu_result into res_data; next state RESP.
- RESP: alu_enable=0, all strobes 0, res_valid=1, res_data/res_dest/res_illegal stable until res_ready. The cycle res_valid&&res_ready -> IDLE; res_valid drops next cycle.
- Illegal: no strobe, no enable; RESP with res_data=0, res_illegal=1, res_dest=rd.
- Latency (accept edge = cycle T): res_valid at T+3 for single-cycle ops, T+2+MULDIV_LAT for mul/div, T+1 for illegal. Back-to-back throughput is one instruction per (latency+1) cycles; no overlap.
- Invariant: at most one op strobe high; strobes are 0 outside SETUP/EXEC; alu_enable is high only in EXEC.
- instr_valid while not in IDLE is ignored (ready=0); instr/rs_val/rt_val are sampled only on acceptance.

Decomposition:
- Package alu_issue_pkg: state enum, funct code constants, alu_op_t one-hot struct (14 bits) with zero constant.
- Sub-module alu_funct_decode (combinational): opcode+funct -> alu_op_t plus is_muldiv and illegal flags. The FSM, counter and capture registers stay in alu_issue_ctrl.

Test Plan:
- rst high 2 cycles, then low -> instr_ready=1; res_valid, alu_enable and all strobes 0.
- add: instr=0x00221820 (rs=1, rt=2, rd=3), rs_val=5, rt_val=7, ALU model returns 12 -> op_add high at T+1..T+2, alu_enable high only at T+2, res_valid at T+3 with res_data=12, res_dest=3, res_illegal=0.
- sll: shamt=4, rt_val=0x1, funct 0x00 -> alu_c=4, op_sll only; res_data=0x10 at T+3.
- div with MULDIV_LAT=4: rs_val=100, rt_val=7 -> alu_enable high exactly 4 cycles; res_data=14 at T+6.
- opcode 0x23 (lw), or funct 0x3F -> no strobe or enable; res_valid at T+1, res_illegal=1, res_data=0.
- res_ready held low 5 cycles in RESP -> outputs stable and instr_ready=0. Also assert rst during EXEC -> IDLE next cycle; alu_enable=0, no res_valid.

Source files
------------

// File: rtl/alu_issue_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_pkg
// Purpose : Shared types and constants for the ALU issue controller.
// Revision: 1.0
// ============================================================================
package alu_issue_pkg;

    // Controller states
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SETUP = 2'd1;
    localparam logic [1:0] S_EXEC  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SLA  = 6'h01;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_MUL  = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;
    localparam logic [5:0] FUNCT_ADD  = 6'h20;
    localparam logic [5:0] FUNCT_ADDU = 6'h21;
    localparam logic [5:0] FUNCT_SUB  = 6'h22;
    localparam logic [5:0] FUNCT_SUBU = 6'h23;
    localparam logic [5:0] FUNCT_AND  = 6'h24;
    localparam logic [5:0] FUNCT_OR   = 6'h25;
    localparam logic [5:0] FUNCT_XOR  = 6'h26;
    localparam logic [5:0] FUNCT_NOR  = 6'h27;

    // One-hot ALU operation strobes, one field per ALU op line
    typedef struct packed {
        logic add;
        logic addu;
        logic sub;
        logic subu;
        logic mul;
        logic div;
        logic band;
        logic bor;
        logic bxor;
        logic bnor;
        logic srl;
        logic sll;
        logic sra;
        logic sla;
    } alu_op_t;

    localparam alu_op_t ALU_OP_ZERO = '0;

    function automatic logic op_is_muldiv(input alu_op_t op);
        return op.mul | op.div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_funct_decode.sv
`default_nettype none
// ============================================================================
// Module  : alu_funct_decode
// Purpose : Combinational R-type opcode/funct decode into one-hot ALU ops.
// Revision: 1.0
// ============================================================================
module alu_funct_decode
    import alu_issue_pkg::*;
(
    input  logic [5:0] opcode_i,
    input  logic [5:0] funct_i,
    output alu_op_t    op_o,
    output logic       is_muldiv_o,
    output logic       illegal_o
);

    always_comb begin
        op_o      = ALU_OP_ZERO;
        illegal_o = 1'b0;
        case (funct_i)
            FUNCT_ADD:  op_o.add  = 1'b1;
            FUNCT_ADDU: op_o.addu = 1'b1;
            FUNCT_SUB:  op_o.sub  = 1'b1;
            FUNCT_SUBU: op_o.subu = 1'b1;
            FUNCT_AND:  op_o.band = 1'b1;
            FUNCT_OR:   op_o.bor  = 1'b1;
            FUNCT_XOR:  op_o.bxor = 1'b1;
            FUNCT_NOR:  op_o.bnor = 1'b1;
            FUNCT_SLL:  op_o.sll  = 1'b1;
            FUNCT_SRL:  op_o.srl  = 1'b1;
            FUNCT_SRA:  op_o.sra  = 1'b1;
            FUNCT_SLA:  op_o.sla  = 1'b1;
            FUNCT_MUL:  op_o.mul  = 1'b1;
            FUNCT_DIV:  op_o.div  = 1'b1;
            default:    illegal_o = 1'b1;
        endcase
        // Non-R-type opcodes never reach the ALU, regardless of funct bits
        if (opcode_i != OPCODE_RTYPE) begin
            op_o      = ALU_OP_ZERO;
            illegal_o = 1'b1;
        end
        is_muldiv_o = op_is_muldiv(op_o);
    end

endmodule
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : alu_issue_ctrl
// Purpose : Accepts an R-type instruction, sequences the ALU, returns result.
// Revision: 1.0
// ============================================================================
module alu_issue_ctrl
    import alu_issue_pkg::*;
#(
    parameter int MULDIV_LAT = 4,
    parameter int DATA_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [31:0]       instr_i,
    input  logic [DATA_W-1:0] rs_val_i,
    input  logic [DATA_W-1:0] rt_val_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [DATA_W-1:0] alu_c_o,
    output logic              op_add_o,
    output logic              op_addu_o,
    output logic              op_sub_o,
    output logic              op_subu_o,
    output logic              op_mul_o,
    output logic              op_div_o,
    output logic              op_and_o,
    output logic              op_or_o,
    output logic              op_xor_o,
    output logic              op_nor_o,
    output logic              op_srl_o,
    output logic              op_sll_o,
    output logic              op_sra_o,
    output logic              op_sla_o,
    output logic              alu_enable_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              res_valid_o,
    input  logic              res_ready_i,
    output logic [DATA_W-1:0] res_data_o,
    output logic [4:0]        res_dest_o,
    output logic              res_illegal_o
);

    localparam int              c_CNT_W      = (MULDIV_LAT > 1) ? $clog2(MULDIV_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MULDIV = c_CNT_W'(MULDIV_LAT - 1);

    logic [1:0]         state_q, state_d;
    alu_op_t            op_q, op_d;
    logic [DATA_W-1:0]  a_q, a_d;
    logic [DATA_W-1:0]  b_q, b_d;
    logic [4:0]         shamt_q, shamt_d;
    logic [4:0]         rd_q, rd_d;
    logic               illegal_q, illegal_d;
    logic [c_CNT_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0]  res_q, res_d;

    alu_op_t            w_dec_op;
    logic               w_dec_muldiv;
    logic               w_dec_illegal;
    alu_op_t            w_op;
    logic               w_unused_regs;

    // Register-index fields are consumed upstream; only rd/shamt/funct matter here
    assign w_unused_regs = ^instr_i[25:16];

    alu_funct_decode u_decode (
        .opcode_i    (instr_i[31:26]),
        .funct_i     (instr_i[5:0]),
        .op_o        (w_dec_op),
        .is_muldiv_o (w_dec_muldiv),
        .illegal_o   (w_dec_illegal)
    );

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        shamt_d   = shamt_q;
        rd_d      = rd_q;
        illegal_d = illegal_q;
        cnt_d     = cnt_q;
        res_d     = res_q;
        case (state_q)
            S_IDLE: begin
                if (instr_valid_i) begin
                    a_d       = rs_val_i;
                    b_d       = rt_val_i;
                    shamt_d   = instr_i[10:6];
                    rd_d      = instr_i[15:11];
                    op_d      = w_dec_op;
                    illegal_d = w_dec_illegal;
                    res_d     = '0;
                    cnt_d     = w_dec_muldiv ? c_CNT_MULDIV : '0;
                    state_d   = w_dec_illegal ? S_RESP : S_SETUP;
                end
            end
            S_SETUP: begin
                state_d = S_EXEC;
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    res_d   = alu_result_i;
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - c_CNT_W'(1);
                end
            end
            S_RESP: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            op_q      <= ALU_OP_ZERO;
            a_q       <= '0;
            b_q       <= '0;
            shamt_q   <= '0;
            rd_q      <= '0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
            res_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            shamt_q   <= shamt_d;
            rd_q      <= rd_d;
            illegal_q <= illegal_d;
            cnt_q     <= cnt_d;
            res_q     <= res_d;
        end
    end

    // Strobes are visible only while the ALU is being set up or run
    assign w_op = ((state_q == S_SETUP) || (state_q == S_EXEC)) ? op_q : ALU_OP_ZERO;

    assign op_add_o  = w_op.add;
    assign op_addu_o = w_op.addu;
    assign op_sub_o  = w_op.sub;
    assign op_subu_o = w_op.subu;
    assign op_mul_o  = w_op.mul;
    assign op_div_o  = w_op.div;
    assign op_and_o  = w_op.band;
    assign op_or_o   = w_op.bor;
    assign op_xor_o  = w_op.bxor;
    assign op_nor_o  = w_op.bnor;
    assign op_srl_o  = w_op.srl;
    assign op_sll_o  = w_op.sll;
    assign op_sra_o  = w_op.sra;
    assign op_sla_o  = w_op.sla;

    assign alu_a_o       = a_q;
    assign alu_b_o       = b_q;
    assign alu_c_o       = {{(DATA_W-5){1'b0}}, shamt_q};
    assign alu_enable_o  = (state_q == S_EXEC);
    assign instr_ready_o = (state_q == S_IDLE);
    assign res_valid_o   = (state_q == S_RESP);
    assign res_data_o    = res_q;
    assign res_dest_o    = rd_q;
    assign res_illegal_o = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_issue_ctrl
// Purpose : Directed + randomized self-checking bench for alu_issue_ctrl.
// Revision: 1.0
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int LAT = 4;
    localparam int DW  = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          instr_valid;
    logic          instr_ready;
    logic [31:0]   instr;
    logic [DW-1:0] rs_val, rt_val;
    logic [DW-1:0] alu_a, alu_b, alu_c;
    logic op_add, op_addu, op_sub, op_subu, op_mul, op_div, op_and;
    logic op_or, op_xor, op_nor, op_srl, op_sll, op_sra, op_sla;
    logic          alu_enable;
    logic [DW-1:0] alu_result;
    logic          res_valid;
    logic          res_ready;
    logic [DW-1:0] res_data;
    logic [4:0]    res_dest;
    logic          res_illegal;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MULDIV_LAT(LAT), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready), .instr_i(instr),
        .rs_val_i(rs_val), .rt_val_i(rt_val),
        .alu_a_o(alu_a), .alu_b_o(alu_b), .alu_c_o(alu_c),
        .op_add_o(op_add), .op_addu_o(op_addu), .op_sub_o(op_sub), .op_subu_o(op_subu),
        .op_mul_o(op_mul), .op_div_o(op_div), .op_and_o(op_and), .op_or_o(op_or),
        .op_xor_o(op_xor), .op_nor_o(op_nor), .op_srl_o(op_srl), .op_sll_o(op_sll),
        .op_sra_o(op_sra), .op_sla_o(op_sla),
        .alu_enable_o(alu_enable), .alu_result_i(alu_result),
        .res_valid_o(res_valid), .res_ready_i(res_ready), .res_data_o(res_data),
        .res_dest_o(res_dest), .res_illegal_o(res_illegal)
    );

    // Op index order: add addu sub subu mul div and or xor nor srl sll sra sla
    logic [13:0] strb;
    assign strb = {op_sla, op_sra, op_sll, op_srl, op_nor, op_xor, op_or, op_and,
                   op_div, op_mul, op_subu, op_sub, op_addu, op_add};

    function automatic int funct_idx(input logic [31:0] ins);
        if (ins[31:26] != 6'h00) return -1;
        case (ins[5:0])
            6'h20: return 0;   6'h21: return 1;   6'h22: return 2;   6'h23: return 3;
            6'h18: return 4;   6'h1A: return 5;   6'h24: return 6;   6'h25: return 7;
            6'h26: return 8;   6'h27: return 9;   6'h02: return 10;  6'h00: return 11;
            6'h03: return 12;  6'h01: return 13;
            default: return -1;
        endcase
    endfunction

    function automatic logic [5:0] legal_funct(input int k);
        case (k)
            0: return 6'h20;  1: return 6'h21;  2: return 6'h22;  3: return 6'h23;
            4: return 6'h18;  5: return 6'h1A;  6: return 6'h24;  7: return 6'h25;
            8: return 6'h26;  9: return 6'h27;  10: return 6'h02; 11: return 6'h00;
            12: return 6'h03; default: return 6'h01;
        endcase
    endfunction

    function automatic logic [31:0] alu_fn(input int idx, input logic [31:0] a,
                                           input logic [31:0] b, input logic [4:0] sh);
        case (idx)
            0, 1:    return a + b;
            2, 3:    return a - b;
            4:       return a * b;
            5:       return (b == 0) ? 32'hFFFF_FFFF : a / b;
            6:       return a & b;
            7:       return a | b;
            8:       return a ^ b;
            9:       return ~(a | b);
            10:      return b >> sh;
            11, 13:  return b << sh;
            12:      return 32'($signed(b) >>> sh);
            default: return 32'h0;
        endcase
    endfunction

    function automatic int lat_of(input logic [31:0] ins);
        int k;
        k = funct_idx(ins);
        if (k < 0) return 1;
        if (k == 4 || k == 5) return 2 + LAT;
        return 3;
    endfunction

    function automatic logic [31:0] rand_instr();
        int r;
        logic [5:0] opc, f;
        r   = $urandom_range(0, 15);
        opc = 6'h00;
        f   = legal_funct($urandom_range(0, 13));
        if (r == 14) opc = 6'($urandom_range(1, 63));
        if (r == 15) f = 6'($urandom);
        return {opc, 10'($urandom), 5'($urandom), 5'($urandom), f};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // ALU stand-in: result is only correct on cycles where a real ALU would have it
    int en_cnt = 0;
    int r_idx, r_n;
    always @(posedge clk) en_cnt <= alu_enable ? en_cnt + 1 : 0;
    always_comb begin
        r_idx = -1;
        r_n   = 0;
        for (int i = 0; i < 14; i++) begin
            if (strb[i]) begin
                r_idx = i;
                r_n   = r_n + 1;
            end
        end
        if (r_n != 1)
            alu_result = 32'hDEAD_BEEF;
        else if (alu_enable && ((r_idx != 4 && r_idx != 5) || en_cnt == LAT - 1))
            alu_result = alu_fn(r_idx, alu_a, alu_b, alu_c[4:0]);
        else
            alu_result = ~alu_fn(r_idx, alu_a, alu_b, alu_c[4:0]);
    end

    // Transaction-level reference: position of the current instruction in its life
    bit          m_init = 1'b0;
    bit          m_busy = 1'b0;
    int          m_k, m_lat, m_idx;
    bit          m_ill;
    logic [31:0] m_a, m_b, m_res;
    logic [4:0]  m_sh, m_rd;

    always @(posedge clk) begin
        if (rst) begin
            m_init <= 1'b1;
            m_busy <= 1'b0;
        end else if (m_init) begin
            if (!m_busy) begin
                if (instr_valid) begin
                    m_busy <= 1'b1;
                    m_k    <= 1;
                    m_idx  <= funct_idx(instr);
                    m_ill  <= (funct_idx(instr) < 0);
                    m_lat  <= lat_of(instr);
                    m_a    <= rs_val;
                    m_b    <= rt_val;
                    m_sh   <= instr[10:6];
                    m_rd   <= instr[15:11];
                    m_res  <= (funct_idx(instr) < 0) ? 32'h0 :
                              alu_fn(funct_idx(instr), rs_val, rt_val, instr[10:6]);
                end
            end else if (m_k >= m_lat && res_ready) begin
                m_busy <= 1'b0;
            end else begin
                m_k <= m_k + 1;
            end
        end
    end

    logic        e_ready, e_valid, e_act, e_en;
    logic [13:0] e_strb;
    assign e_ready = !m_busy;
    assign e_valid = m_busy && (m_k >= m_lat);
    assign e_act   = m_busy && !m_ill && (m_k < m_lat);
    assign e_strb  = e_act ? (14'd1 << m_idx) : 14'd0;
    assign e_en    = e_act && (m_k >= 2);

    always @(negedge clk) begin
        if (m_init) begin
            check("instr_ready", instr_ready, e_ready);
            check("res_valid", res_valid, e_valid);
            check("strobes", strb, e_strb);
            check("alu_enable", alu_enable, e_en);
            if (e_act) begin
                check("alu_a", alu_a, m_a);
                check("alu_b", alu_b, m_b);
                check("alu_c", alu_c, {27'd0, m_sh});
            end
            if (e_valid) begin
                check("res_data", res_data, m_res);
                check("res_dest", res_dest, m_rd);
                check("res_illegal", res_illegal, m_ill);
            end
        end
    end

    // Issues one instruction from IDLE, measures latency/enable cycles, stalls RESP
    task automatic run_dir(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                           input int stall, output int lat, output int en_cyc,
                           output logic [31:0] data, output logic ill, output logic [4:0] dest);
        instr_valid = 1'b1; instr = ins; rs_val = a; rt_val = b; res_ready = 1'b0;
        @(posedge clk); #1;
        instr_valid = 1'b0; instr = $urandom; rs_val = $urandom; rt_val = $urandom;
        lat = -1; en_cyc = 0; data = 'x; ill = 1'bx; dest = 'x;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            @(negedge clk);
            if (alu_enable) en_cyc++;
            if (res_valid) begin
                lat = k; data = res_data; ill = res_illegal; dest = res_dest;
            end else begin
                @(posedge clk); #1;
            end
        end
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); @(negedge clk);
            check("stall_valid", res_valid, 1'b1);
            check("stall_data", res_data, data);
            check("stall_ready", instr_ready, 1'b0);
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    int lat, en_cyc;
    logic [31:0] data;
    logic ill;
    logic [4:0] dest;

    initial begin
        instr_valid = 1'b0; instr = '0; rs_val = '0; rt_val = '0; res_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", instr_ready, 1'b1);
        check("rst_valid", res_valid, 1'b0);
        check("rst_enable", alu_enable, 1'b0);
        check("rst_strobes", strb, 14'd0);
        check("rst_data", res_data, 32'd0);
        @(posedge clk); #1;

        run_dir(32'h0022_1820, 32'd5, 32'd7, 0, lat, en_cyc, data, ill, dest);
        check("add_lat", lat, 3);
        check("add_en", en_cyc, 1);
        check("add_data", data, 32'd12);
        check("add_dest", dest, 5'd3);
        check("add_ill", ill, 1'b0);

        run_dir(32'h0000_2900, 32'd9, 32'd1, 0, lat, en_cyc, data, ill, dest);
        check("sll_lat", lat, 3);
        check("sll_data", data, 32'h10);
        check("sll_dest", dest, 5'd5);

        run_dir(32'h0000_381A, 32'd100, 32'd7, 0, lat, en_cyc, data, ill, dest);
        check("div_lat", lat, 2 + LAT);
        check("div_en", en_cyc, LAT);
        check("div_data", data, 32'd14);

        run_dir(32'h0000_2018, 32'd6, 32'd7, 5, lat, en_cyc, data, ill, dest);
        check("mul_lat", lat, 2 + LAT);
        check("mul_data", data, 32'd42);

        run_dir(32'h8C00_4820, 32'd3, 32'd4, 0, lat, en_cyc, data, ill, dest);
        check("lw_lat", lat, 1);
        check("lw_en", en_cyc, 0);
        check("lw_ill", ill, 1'b1);
        check("lw_data", data, 32'd0);
        check("lw_dest", dest, 5'd9);

        run_dir(32'h0000_103F, 32'd3, 32'd4, 2, lat, en_cyc, data, ill, dest);
        check("f3f_lat", lat, 1);
        check("f3f_ill", ill, 1'b1);

        // Reset while a divide is executing
        instr_valid = 1'b1; instr = 32'h0000_381A; rs_val = 32'd50; rt_val = 32'd5;
        @(posedge clk); #1 instr_valid = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_enable", alu_enable, 1'b1);
        rst = 1'b1;
        res_ready = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("abort_enable", alu_enable, 1'b0);
        check("abort_valid", res_valid, 1'b0);
        check("abort_ready", instr_ready, 1'b1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("abort_no_result", res_valid, 1'b0);
        end
        @(posedge clk); #1;

        repeat (4000) begin
            instr_valid = ($urandom_range(0, 2) != 0);
            instr       = rand_instr();
            rs_val      = $urandom;
            rt_val      = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            res_ready   = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        res_ready   = 1'b1;
        repeat (20) @(posedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
